control_sequencer: RTL and testbench

//  Hard-wired Moore control unit upstream of the single-bus Datapath; it drives all datapath strobes.

---
 rtl/control_sequencer.sv | 156 +++++++++++++++
 tb/tb_control_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit for the single-bus datapath: fetch (T0-T2) plus a
// three-step register-register ALU execute (T3-T5), with HALT/illegal handling.
module control_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [4:0]  OP_ADD  = 5'b01001,
    parameter logic [4:0]  OP_SUB  = 5'b01010,
    parameter logic [4:0]  OP_AND  = 5'b01011,
    parameter logic [4:0]  OP_OR   = 5'b01100,
    parameter logic [4:0]  OP_HALT = 5'b11011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [3:0]       alu_op,
    output logic             done,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_T0     = 4'd1;
    localparam logic [3:0] S_T1     = 4'd2;
    localparam logic [3:0] S_T2     = 4'd3;
    localparam logic [3:0] S_T3     = 4'd4;
    localparam logic [3:0] S_T4     = 4'd5;
    localparam logic [3:0] S_T5     = 4'd6;
    localparam logic [3:0] S_HALTED = 4'd7;
    localparam logic [3:0] S_FAULT  = 4'd8;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [4:0] opcode;
    logic       is_alu;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_OR);
    // Register fields are consumed by the datapath's select/encode logic, not here.
    assign unused_ir = ^ir[26:0];

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_T5) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic and strobe decode of the registered state
    always_comb begin
        next_state = state;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        alu_op     = 4'd0;
        done       = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) next_state = S_T0;
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) next_state = S_T2;
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    Grb        = 1'b1;
                    Rout       = 1'b1;
                    Yin        = 1'b1;
                    next_state = S_T4;
                end else if (opcode == OP_HALT) begin
                    next_state = S_HALTED;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_T4: begin
                Grc        = 1'b1;
                Rout       = 1'b1;
                Zin        = 1'b1;
                next_state = S_T5;
                if (opcode == OP_ADD)      alu_op = 4'd1;
                else if (opcode == OP_SUB) alu_op = 4'd2;
                else if (opcode == OP_AND) alu_op = 4'd3;
                else if (opcode == OP_OR)  alu_op = 4'd4;
            end
            S_T5: begin
                Zlowout    = 1'b1;
                Gra        = 1'b1;
                Rin        = 1'b1;
                done       = 1'b1;
                next_state = run ? S_T0 : S_IDLE;
            end
            S_HALTED: halted  = 1'b1;
            S_FAULT:  illegal = 1'b1;
            default:  next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected strobe vectors go through a
// scoreboard queue and are compared against the DUT one cycle at a time.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready;
    logic [31:0] ir;
    logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic Gra, Grb, Grc, Rin, Rout, done, halted, illegal;
    logic [3:0]  alu_op;
    logic [15:0] instr_count;

    logic        reset2, run2;
    logic [31:0] ir2;
    logic PCout2, Zlowout2, MDRout2, MARin2, Zin2, PCin2, MDRin2, IRin2, Yin2, IncPC2, Read2;
    logic Gra2, Grb2, Grc2, Rin2, Rout2, done2, halted2, illegal2;
    logic [3:0]  alu_op2;
    logic [1:0]  instr_count2;

    int tests = 0;
    int fails = 0;

    localparam logic [22:0] M_PCOUT   = 23'(1) << 22;
    localparam logic [22:0] M_ZLOW    = 23'(1) << 21;
    localparam logic [22:0] M_MDROUT  = 23'(1) << 20;
    localparam logic [22:0] M_MARIN   = 23'(1) << 19;
    localparam logic [22:0] M_ZIN     = 23'(1) << 18;
    localparam logic [22:0] M_PCIN    = 23'(1) << 17;
    localparam logic [22:0] M_MDRIN   = 23'(1) << 16;
    localparam logic [22:0] M_IRIN    = 23'(1) << 15;
    localparam logic [22:0] M_YIN     = 23'(1) << 14;
    localparam logic [22:0] M_INCPC   = 23'(1) << 13;
    localparam logic [22:0] M_READ    = 23'(1) << 12;
    localparam logic [22:0] M_GRA     = 23'(1) << 11;
    localparam logic [22:0] M_GRB     = 23'(1) << 10;
    localparam logic [22:0] M_GRC     = 23'(1) << 9;
    localparam logic [22:0] M_RIN     = 23'(1) << 8;
    localparam logic [22:0] M_ROUT    = 23'(1) << 7;
    localparam logic [22:0] M_DONE    = 23'(1) << 2;
    localparam logic [22:0] M_HALTED  = 23'(1) << 1;
    localparam logic [22:0] M_ILLEGAL = 23'(1);

    localparam logic [22:0] E_IDLE = 23'd0;
    localparam logic [22:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [22:0] E_T1   = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [22:0] E_T2   = M_MDROUT | M_IRIN;
    localparam logic [22:0] E_T3   = M_GRB | M_ROUT | M_YIN;
    localparam logic [22:0] E_T5   = M_ZLOW | M_GRA | M_RIN | M_DONE;

    localparam logic [31:0] IR_ADD  = 32'h4A920000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    logic [22:0] obs;
    logic [22:0] sb[$];

    assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
                  Gra, Grb, Grc, Rin, Rout, alu_op, done, halted, illegal};

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
        .done(done), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    control_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .run(run2), .mem_ready(1'b1), .ir(ir2),
        .PCout(PCout2), .Zlowout(Zlowout2), .MDRout(MDRout2), .MARin(MARin2), .Zin(Zin2),
        .PCin(PCin2), .MDRin(MDRin2), .IRin(IRin2), .Yin(Yin2), .IncPC(IncPC2), .Read(Read2),
        .Gra(Gra2), .Grb(Grb2), .Grc(Grc2), .Rin(Rin2), .Rout(Rout2), .alu_op(alu_op2),
        .done(done2), .halted(halted2), .illegal(illegal2), .instr_count(instr_count2)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] e_t4(input logic [3:0] op);
        return M_GRC | M_ROUT | M_ZIN | (23'(op) << 3);
    endfunction

    // Push the expected vector, advance one edge, pop and compare
    task automatic cyc(input logic [22:0] e, input string tag);
        logic [22:0] want;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chk_cnt(input logic [15:0] e, input string tag);
        tests++;
        assert (instr_count === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, instr_count, e);
        end
    endtask

    // Full ALU instruction starting from IDLE/T5 with mem_ready=1; run dropped after T0
    task automatic alu_instr(input logic [31:0] instr, input logic [3:0] op, input string tag);
        ir = instr;
        run = 1'b1;
        cyc(E_T0, {tag, "_t0"});
        run = 1'b0;
        cyc(E_T1, {tag, "_t1"});
        cyc(E_T2, {tag, "_t2"});
        cyc(E_T3, {tag, "_t3"});
        cyc(e_t4(op), {tag, "_t4"});
        cyc(E_T5, {tag, "_t5"});
        cyc(E_IDLE, {tag, "_idle"});
    endtask

    initial begin
        logic [1:0] exp_cnt2;
        logic       exp_done2;
        int         d2_fails;

        reset = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = IR_ADD;
        reset2 = 1'b1; run2 = 1'b0; ir2 = IR_ADD;
        cyc(E_IDLE, "reset_state");
        chk_cnt(16'd0, "reset_count");
        reset = 1'b0; reset2 = 1'b0;

        // 1: ADD with memory always ready
        alu_instr(IR_ADD, 4'd1, "add");
        chk_cnt(16'd1, "add_count");

        // 2: three wait states in T1, done lands on cycle 9
        run = 1'b1;
        cyc(E_T0, "wait_t0");
        mem_ready = 1'b0;
        run = 1'b0;
        cyc(E_T1, "wait_t1_a");
        cyc(E_T1, "wait_t1_b");
        cyc(E_T1, "wait_t1_c");
        cyc(E_T1, "wait_t1_d");
        mem_ready = 1'b1;
        cyc(E_T2, "wait_t2");
        cyc(E_T3, "wait_t3");
        cyc(e_t4(4'd1), "wait_t4");
        cyc(E_T5, "wait_done_c9");
        cyc(E_IDLE, "wait_idle");
        chk_cnt(16'd2, "wait_count");

        // Remaining ALU opcodes
        alu_instr(32'h50000000, 4'd2, "sub");
        alu_instr(32'h58000000, 4'd3, "and");
        alu_instr(32'h60000000, 4'd4, "or");
        chk_cnt(16'd5, "ops_count");

        // 3: illegal opcode faults after T3 and is sticky until reset
        ir = IR_BAD; run = 1'b1;
        cyc(E_T0, "bad_t0");
        cyc(E_T1, "bad_t1");
        cyc(E_T2, "bad_t2");
        cyc(E_IDLE, "bad_t3_nostrobe");
        cyc(M_ILLEGAL, "fault_a");
        cyc(M_ILLEGAL, "fault_b");
        chk_cnt(16'd5, "fault_count");
        reset = 1'b1;
        cyc(E_IDLE, "fault_reset");
        chk_cnt(16'd0, "fault_reset_count");
        reset = 1'b0; run = 1'b0;
        cyc(E_IDLE, "fault_reset_idle");

        // 4: HALT parks with run ignored and count unchanged
        alu_instr(IR_ADD, 4'd1, "pre_halt");
        ir = IR_HALT; run = 1'b1;
        cyc(E_T0, "halt_t0");
        cyc(E_T1, "halt_t1");
        cyc(E_T2, "halt_t2");
        cyc(E_IDLE, "halt_t3_nostrobe");
        cyc(M_HALTED, "halted_a");
        cyc(M_HALTED, "halted_b");
        cyc(M_HALTED, "halted_c");
        chk_cnt(16'd1, "halt_count");
        reset = 1'b1;
        cyc(E_IDLE, "halt_reset");
        reset = 1'b0; run = 1'b0;

        // 5: reset mid-instruction during T4, then restart; reset beats run
        ir = IR_ADD; run = 1'b1;
        cyc(E_T0, "mid_t0");
        cyc(E_T1, "mid_t1");
        cyc(E_T2, "mid_t2");
        cyc(E_T3, "mid_t3");
        cyc(e_t4(4'd1), "mid_t4");
        reset = 1'b1;
        cyc(E_IDLE, "mid_reset");
        chk_cnt(16'd0, "mid_reset_count");
        reset = 1'b0;
        cyc(E_T0, "restart_t0");
        run = 1'b0;
        cyc(E_T1, "restart_t1");
        cyc(E_T2, "restart_t2");
        cyc(E_T3, "restart_t3");
        cyc(e_t4(4'd1), "restart_t4");
        cyc(E_T5, "restart_t5");
        cyc(E_IDLE, "restart_idle");
        chk_cnt(16'd1, "restart_count");

        // 6: 2-bit counter, five back-to-back ADDs; count seen in cycle k is (k-1)/6 mod 4
        run2 = 1'b1;
        d2_fails = 0;
        for (int k = 1; k <= 31; k++) begin
            if (k == 30) run2 = 1'b0;
            @(posedge clk);
            #1;
            exp_cnt2  = 2'((k - 1) / 6);
            exp_done2 = ((k % 6) == 0);
            tests++;
            assert ((instr_count2 === exp_cnt2) && (done2 === exp_done2)) else begin
                fails++;
                d2_fails++;
                $error("FAIL wrap_cycle%0d observed=cnt%0d/done%0b expected=cnt%0d/done%0b",
                       k, instr_count2, done2, exp_cnt2, exp_done2);
            end
        end
        tests++;
        assert (instr_count2 === 2'd1) else begin
            fails++;
            $error("FAIL wrap_final observed=%0d expected=1", instr_count2);
        end

        if (sb.size() != 0) begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
